// File: rtl/stream_sink_harness_if.sv
// Handshake bundle between the stream sink harness (master) and the stream-dialect DUT (slave).
interface stream_sink_harness_if #(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned DATA_W = 64
);
    logic                     in_ctrl_valid;
    logic                     in_ctrl_ready;
    logic [NUM_CH-1:0]        ch_valid;
    logic [NUM_CH-1:0]        ch_ready;
    logic [NUM_CH*DATA_W-1:0] ch_data;
    logic [NUM_CH-1:0]        ch_eos;

    modport master (
        output in_ctrl_valid, ch_ready,
        input  in_ctrl_ready, ch_valid, ch_data, ch_eos
    );

    modport slave (
        input  in_ctrl_valid, ch_ready,
        output in_ctrl_ready, ch_valid, ch_data, ch_eos
    );
endinterface

// File: rtl/stream_sink_harness.sv
// Harness controller: fires one control token, drains NUM_CH {data, eos} streams, reports pass/fail.
// Optional macro BACKPRESSURE_EN adds LFSR-driven ready throttling and a stall-stability protocol check.
module stream_sink_harness #(
    parameter int unsigned NUM_CH    = 2,
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned TIMEOUT   = 1024,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                     clock,
    input  logic                     reset,
    stream_sink_harness_if.master    bus,
    output logic [NUM_CH-1:0]        ch_done,
    output logic [NUM_CH*32-1:0]     elem_count,
    output logic [NUM_CH*DATA_W-1:0] checksum,
    output logic                     all_done,
    output logic                     fail,
    output logic [NUM_CH-1:0]        proto_err
);
    localparam int unsigned CNT_W  = 32;
    localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_RUN, S_DONE, S_FAIL} state_e;

    state_e                         state_q, state_d;
    logic [NUM_CH-1:0][CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_CH-1:0][DATA_W-1:0]  sum_q, sum_d;
    logic [NUM_CH-1:0]              done_q, done_d, ready_q, ready_d, perr_q, perr_d, acc;
    logic [IDLE_W-1:0]              idle_q, idle_d;
    logic                           ctrl_valid_q, ctrl_valid_d;
    logic                           all_done_q, all_done_d, fail_q, fail_d;
    logic                           inc_en, timeout_c;
`ifdef BACKPRESSURE_EN
    logic [15:0]                    lfsr_q, lfsr_d;
    logic [NUM_CH-1:0]              pend_q, pend_d, hold_eos_q, hold_eos_d;
    logic [NUM_CH-1:0][DATA_W-1:0]  hold_data_q, hold_data_d;
`else
    logic                           unused_seed;
    assign unused_seed = ^LFSR_SEED;
`endif

    // Datapath next-state: accepts, counters, checksums, idle counter, protocol check
    always_comb begin
        acc    = (state_q == S_RUN) ? (bus.ch_valid & ready_q) : '0;
        cnt_d  = cnt_q;
        sum_d  = sum_q;
        done_d = done_q;
        perr_d = perr_q;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (acc[i]) begin
                if (bus.ch_eos[i]) begin
                    done_d[i] = 1'b1;
                end else begin
                    if (cnt_q[i] != '1) cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    sum_d[i] = sum_q[i] + bus.ch_data[i*DATA_W +: DATA_W];
                end
            end
        end
`ifdef BACKPRESSURE_EN
        lfsr_d      = (state_q == S_RUN)
                    ? {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]}
                    : lfsr_q;
        inc_en      = |ready_q;
        pend_d      = '0;
        hold_eos_d  = bus.ch_eos;
        hold_data_d = bus.ch_data;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            // A beat offered while stalled must stay put until it is taken
            pend_d[i] = (state_q == S_RUN) && bus.ch_valid[i] && !ready_q[i] && !done_q[i];
            if ((state_q == S_RUN) && pend_q[i] &&
                (!bus.ch_valid[i] || (bus.ch_eos[i] != hold_eos_q[i]) ||
                 (bus.ch_data[i*DATA_W +: DATA_W] != hold_data_q[i])))
                perr_d[i] = 1'b1;
        end
`else
        inc_en = 1'b1;
`endif
        idle_d    = idle_q;
        timeout_c = 1'b0;
        if (state_q == S_START) begin
            idle_d = '0;
        end else if (state_q == S_RUN) begin
            if (|acc) begin
                idle_d = '0;
            end else if (inc_en) begin
                idle_d    = idle_q + IDLE_W'(1);
                timeout_c = (idle_q == IDLE_W'(TIMEOUT - 1));
            end
        end
    end

    // FSM next state; FAIL beats DONE on a same-cycle protocol error
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = S_START;
            S_START: if (ctrl_valid_q && bus.in_ctrl_ready) state_d = S_RUN;
            S_RUN: begin
                if (|perr_d)        state_d = S_FAIL;
                else if (&done_d)   state_d = S_DONE;
                else if (timeout_c) state_d = S_FAIL;
            end
            default: state_d = state_q;
        endcase
    end

    // Output next values, decoded from the next state so the outputs can be registered
    always_comb begin
        ctrl_valid_d = (state_d == S_START);
        all_done_d   = (state_d == S_DONE);
        fail_d       = (state_d == S_FAIL);
        ready_d      = (state_d == S_RUN) ? ~done_d : '0;
`ifdef BACKPRESSURE_EN
        for (int i = 0; i < int'(NUM_CH); i++) begin
            ready_d[i] = ready_d[i] & lfsr_d[i % 16];
        end
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q        <= '0;
            sum_q        <= '0;
            done_q       <= '0;
            perr_q       <= '0;
            ready_q      <= '0;
            idle_q       <= '0;
            ctrl_valid_q <= 1'b0;
            all_done_q   <= 1'b0;
            fail_q       <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            sum_q        <= sum_d;
            done_q       <= done_d;
            perr_q       <= perr_d;
            ready_q      <= ready_d;
            idle_q       <= idle_d;
            ctrl_valid_q <= ctrl_valid_d;
            all_done_q   <= all_done_d;
            fail_q       <= fail_d;
        end
    end

`ifdef BACKPRESSURE_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lfsr_q      <= LFSR_SEED;
            pend_q      <= '0;
            hold_eos_q  <= '0;
            hold_data_q <= '0;
        end else begin
            lfsr_q      <= lfsr_d;
            pend_q      <= pend_d;
            hold_eos_q  <= hold_eos_d;
            hold_data_q <= hold_data_d;
        end
    end
`endif

    assign bus.in_ctrl_valid = ctrl_valid_q;
    assign bus.ch_ready      = ready_q;
    assign ch_done           = done_q;
    assign elem_count        = cnt_q;
    assign checksum          = sum_q;
    assign all_done          = all_done_q;
    assign fail              = fail_q;
    assign proto_err         = perr_q;
endmodule

// File: tb/tb_stream_sink_harness.sv
// Scoreboard bench for stream_sink_harness: NUM_CH=2, DATA_W=8, TIMEOUT=16.
module tb_stream_sink_harness;
    localparam int unsigned NCH = 2;
    localparam int unsigned DW  = 8;
    localparam int unsigned TO  = 16;

    typedef struct {
        int          ch;
        logic [31:0] cnt;
        logic [DW-1:0] sum;
        logic        done;
    } exp_t;

    logic                 clock;
    logic                 reset;
    logic [NCH-1:0]       ch_done;
    logic [NCH*32-1:0]    elem_count;
    logic [NCH*DW-1:0]    checksum;
    logic                 all_done;
    logic                 fail;
    logic [NCH-1:0]       proto_err;

    int checks = 0;
    int errors = 0;
    int tokens = 0;
    exp_t sbq[$];
    logic [31:0]   m_cnt [NCH];
    logic [DW-1:0] m_sum [NCH];
    logic          m_done[NCH];

    stream_sink_harness_if #(.NUM_CH(NCH), .DATA_W(DW)) bus();

    stream_sink_harness #(.NUM_CH(NCH), .DATA_W(DW), .TIMEOUT(TO), .LFSR_SEED(16'hACE1)) dut (
        .clock(clock), .reset(reset), .bus(bus),
        .ch_done(ch_done), .elem_count(elem_count), .checksum(checksum),
        .all_done(all_done), .fail(fail), .proto_err(proto_err)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (!reset && bus.in_ctrl_valid && bus.in_ctrl_ready) tokens++;
    end

    task automatic apply_reset();
        reset = 1'b1;
        bus.ch_valid = '0; bus.ch_eos = '0; bus.ch_data = '0; bus.in_ctrl_ready = 1'b0;
        #1;
        checks++;
        if ({elem_count, checksum, ch_done, all_done, fail, proto_err, bus.ch_ready, bus.in_ctrl_valid} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got cnt=%h sum=%h done=%b ad=%b f=%b pe=%b rdy=%b cv=%b, want all 0",
                     elem_count, checksum, ch_done, all_done, fail, proto_err, bus.ch_ready, bus.in_ctrl_valid);
        end
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        tokens = 0;
        for (int i = 0; i < int'(NCH); i++) begin m_cnt[i] = '0; m_sum[i] = '0; m_done[i] = 1'b0; end
    endtask

    // Ready the control token on the third cycle valid is seen
    task automatic start_run();
        int vc = 0;
        bit early = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clock); #1;
            if (bus.in_ctrl_valid) begin
                vc++;
                if (bus.ch_ready !== '0) early = 1;
                if (vc == 3) bus.in_ctrl_ready = 1'b1;
            end else if (vc > 0) begin
                break;
            end
        end
        bus.in_ctrl_ready = 1'b0;
        checks++;
        if (vc != 3 || early) begin
            errors++;
            $display("FAIL ctrl_token: valid high %0d cycles (early ready=%0d), want 3 cycles and ready 0", vc, early);
        end
    endtask

    task automatic send_beat(input int ch, input logic [DW-1:0] d, input logic e);
        int n = 0;
        bit ok = 0;
        exp_t x;
        bus.ch_valid[ch] = 1'b1;
        bus.ch_data[ch*DW +: DW] = d;
        bus.ch_eos[ch] = e;
        while (n < 40) begin
            if (bus.ch_ready[ch]) begin
                @(posedge clock); #1;
                ok = 1;
                break;
            end
            @(posedge clock); #1;
            n++;
        end
        bus.ch_valid[ch] = 1'b0;
        bus.ch_eos[ch] = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL accept_ch%0d: no accept within %0d cycles, want accept", ch, n);
            return;
        end
        if (e) m_done[ch] = 1'b1;
        else begin m_cnt[ch] = m_cnt[ch] + 32'd1; m_sum[ch] = m_sum[ch] + d; end
        sbq.push_back('{ch, m_cnt[ch], m_sum[ch], m_done[ch]});
        while (sbq.size() > 0) begin
            x = sbq.pop_front();
            checks++;
            if (elem_count[x.ch*32 +: 32] !== x.cnt || checksum[x.ch*DW +: DW] !== x.sum ||
                ch_done[x.ch] !== x.done) begin
                errors++;
                $display("FAIL beat_ch%0d: got cnt=%0d sum=%0d done=%b, want cnt=%0d sum=%0d done=%b",
                         x.ch, elem_count[x.ch*32 +: 32], checksum[x.ch*DW +: DW], ch_done[x.ch],
                         x.cnt, x.sum, x.done);
            end
        end
    endtask

    task automatic test_reset();
        apply_reset();
    endtask

    task automatic test_basic();
        apply_reset();
        start_run();
        send_beat(0, 8'd5, 1'b0);
        send_beat(0, 8'd7, 1'b0);
        send_beat(1, 8'd100, 1'b0);
        send_beat(1, 8'd0, 1'b1);
        checks++;
        if (all_done !== 1'b0) begin errors++; $display("FAIL early_done: got %b want 0", all_done); end
        send_beat(0, 8'd0, 1'b1);
        checks++;
        if (all_done !== 1'b1 || fail !== 1'b0 || elem_count !== {32'd1, 32'd2} || checksum !== {8'd100, 8'd12}) begin
            errors++;
            $display("FAIL basic_final: got ad=%b f=%b cnt=%h sum=%h, want ad=1 f=0 cnt=%h sum=%h",
                     all_done, fail, elem_count, checksum, {32'd1, 32'd2}, {8'd100, 8'd12});
        end
        repeat (3) @(posedge clock); #1;
        checks++;
        if (tokens != 1 || bus.in_ctrl_valid !== 1'b0 || bus.ch_ready !== '0) begin
            errors++;
            $display("FAIL one_token: got tokens=%0d cv=%b rdy=%b, want 1 0 00", tokens, bus.in_ctrl_valid, bus.ch_ready);
        end
    endtask

    task automatic test_wrap_and_post_eos();
        apply_reset();
        start_run();
        send_beat(0, 8'd200, 1'b0);
        send_beat(0, 8'd100, 1'b0);
        send_beat(0, 8'd0, 1'b1);
        checks++;
        if (checksum[7:0] !== 8'd44) begin errors++; $display("FAIL wrap_sum: got %0d want 44", checksum[7:0]); end
        bus.ch_valid[0] = 1'b1; bus.ch_data[7:0] = 8'd9;
        for (int k = 0; k < 3; k++) begin
            @(posedge clock); #1;
            checks++;
            if (bus.ch_ready[0] !== 1'b0 || elem_count[31:0] !== 32'd2) begin
                errors++;
                $display("FAIL post_eos: got rdy0=%b cnt0=%0d, want 0 and 2", bus.ch_ready[0], elem_count[31:0]);
            end
        end
        bus.ch_valid[0] = 1'b0;
        send_beat(1, 8'd0, 1'b1);
        checks++;
        if (all_done !== 1'b1 || elem_count[31:0] !== 32'd2) begin
            errors++;
            $display("FAIL wrap_final: got ad=%b cnt0=%0d, want 1 and 2", all_done, elem_count[31:0]);
        end
    endtask

    task automatic test_timeout();
        int n = 0;
        apply_reset();
        start_run();
        while (n < 200 && fail !== 1'b1) begin @(posedge clock); #1; n++; end
        checks++;
`ifdef BACKPRESSURE_EN
        if (fail !== 1'b1 || all_done !== 1'b0 || bus.ch_ready !== '0) begin
`else
        if (n != int'(TO) || fail !== 1'b1 || all_done !== 1'b0 || bus.ch_ready !== '0) begin
`endif
            errors++;
            $display("FAIL timeout: got n=%0d f=%b ad=%b rdy=%b, want n=%0d f=1 ad=0 rdy=00",
                     n, fail, all_done, bus.ch_ready, TO);
        end
    endtask

    task automatic test_mid_reset();
        apply_reset();
        start_run();
        send_beat(0, 8'd1, 1'b0);
        send_beat(0, 8'd2, 1'b0);
        send_beat(0, 8'd3, 1'b0);
        reset = 1'b1;
        #1;
        checks++;
        if (elem_count !== '0 || checksum !== '0 || bus.ch_ready !== '0) begin
            errors++;
            $display("FAIL mid_reset: got cnt=%h sum=%h rdy=%b, want 0", elem_count, checksum, bus.ch_ready);
        end
        @(posedge clock); #1 reset = 1'b0;
        tokens = 0;
        for (int i = 0; i < int'(NCH); i++) begin m_cnt[i] = '0; m_sum[i] = '0; m_done[i] = 1'b0; end
        start_run();
        send_beat(1, 8'd50, 1'b0);
        send_beat(0, 8'd9, 1'b0);
        send_beat(0, 8'd0, 1'b1);
        send_beat(1, 8'd0, 1'b1);
        checks++;
        if (tokens != 1 || all_done !== 1'b1 || fail !== 1'b0 || elem_count !== {32'd1, 32'd1} ||
            checksum !== {8'd50, 8'd9}) begin
            errors++;
            $display("FAIL rerun: got tok=%0d ad=%b f=%b cnt=%h sum=%h, want 1 1 0 %h %h",
                     tokens, all_done, fail, elem_count, checksum, {32'd1, 32'd1}, {8'd50, 8'd9});
        end
    endtask

`ifdef BACKPRESSURE_EN
    task automatic test_proto();
        int n = 0;
        apply_reset();
        start_run();
        while (n < 40 && bus.ch_ready[1] !== 1'b0) begin @(posedge clock); #1; n++; end
        bus.ch_valid[1] = 1'b1; bus.ch_data[15:8] = 8'h3C;
        @(posedge clock); #1;
        bus.ch_valid[1] = 1'b0;
        @(posedge clock); #1;
        checks++;
        if (proto_err !== 2'b10) begin errors++; $display("FAIL proto_err: got %b want 10", proto_err); end
        @(posedge clock); #1;
        checks++;
        if (fail !== 1'b1 || bus.ch_ready !== '0 || all_done !== 1'b0) begin
            errors++;
            $display("FAIL proto_fail: got f=%b rdy=%b ad=%b, want 1 00 0", fail, bus.ch_ready, all_done);
        end
    endtask
`endif

    initial begin
        clock = 1'b0;
        reset = 1'b1;
        bus.ch_valid = '0; bus.ch_eos = '0; bus.ch_data = '0; bus.in_ctrl_ready = 1'b0;
        test_reset();
        test_basic();
        test_wrap_and_post_eos();
        test_timeout();
        test_mid_reset();
`ifdef BACKPRESSURE_EN
        test_proto();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
